// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
// sobel_window_gen : 3x3 neighbourhood generator feeding the Sobel kernel,
//                    with zero/replicate edge padding and frame markers.
// Revision: 1.0
// ============================================================================
module sobel_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 5,
  parameter int COLS       = 6,
  parameter int PAD_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [DATA_WIDTH-1:0]   top_i,
  input  logic [DATA_WIDTH-1:0]   mid_i,
  input  logic [DATA_WIDTH-1:0]   bot_i,
  output logic [9*DATA_WIDTH-1:0] win_o,
  output logic                    valid_o,
  output logic                    sof_o,
  output logic                    eol_o,
  output logic                    done_o
);

  localparam int c_col_w = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int c_row_w = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [c_col_w-1:0] c_col_last  = c_col_w'(COLS - 1);
  localparam logic [c_col_w-1:0] c_col_first = c_col_w'(1);
  localparam logic [c_row_w-1:0] c_row_last  = c_row_w'(ROWS - 1);
  localparam bit c_pad = (PAD_MODE != 0);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_col_w-1:0] r_col;
  logic [c_row_w-1:0] r_row;

  // lane index: 0 = top, 1 = mid, 2 = bot
  logic [2:0][DATA_WIDTH-1:0] r_c;
  logic [2:0][DATA_WIDTH-1:0] r_r;
  logic [2:0][DATA_WIDTH-1:0] w_in;
  logic [2:0][DATA_WIDTH-1:0] w_left;
  logic [2:0][DATA_WIDTH-1:0] w_ctr;
  logic [2:0][DATA_WIDTH-1:0] w_right;

  logic [9*DATA_WIDTH-1:0] w_win;
  logic [9*DATA_WIDTH-1:0] r_win;
  logic r_valid;
  logic r_sof;
  logic r_eol;
  logic r_done;

  logic w_ready;
  logic w_accept;
  logic w_emit_run;
  logic w_emit_flush;

  assign w_ready  = (r_state == S_FILL) || (r_state == S_RUN);
  assign ready_o  = rst_n & w_ready;
  assign w_accept = valid_i & ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_emit_run   = 1'b0;
    w_emit_flush = 1'b0;
    case (r_state)
      S_FILL: begin
        if (w_accept) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_accept) begin
          w_emit_run = 1'b1;
          if (r_col == c_col_last) w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_emit_flush = 1'b1;
        w_state_nxt  = (r_row == c_row_last) ? S_DONE : S_FILL;
      end
      S_DONE: begin
        w_state_nxt = S_FILL;
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  always_comb begin
    w_in[1] = mid_i;
    w_in[0] = (r_row == '0)         ? (c_pad ? mid_i : '0) : top_i;
    w_in[2] = (r_row == c_row_last) ? (c_pad ? mid_i : '0) : bot_i;
  end

  // The window is assembled from C/R before the shift plus the incoming
  // column, so the previous column (C) doubles as the left column and no
  // separate L register is needed.
  always_comb begin
    w_left  = r_c;
    w_ctr   = r_r;
    w_right = w_in;
    if (r_state == S_FLUSH) begin
      w_right = c_pad ? r_r : '0;
    end else if (r_col == c_col_first) begin
      w_left = c_pad ? r_r : '0;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_lane
    assign w_win[(3*k+0)*DATA_WIDTH +: DATA_WIDTH] = w_left[k];
    assign w_win[(3*k+1)*DATA_WIDTH +: DATA_WIDTH] = w_ctr[k];
    assign w_win[(3*k+2)*DATA_WIDTH +: DATA_WIDTH] = w_right[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c     <= '0;
      r_r     <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_win   <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_c   <= r_r;
        r_r   <= w_in;
        r_col <= (r_col == c_col_last) ? '0 : r_col + 1'b1;
      end
      if (w_emit_run || w_emit_flush) begin
        r_win   <= w_win;
        r_valid <= 1'b1;
        r_sof   <= w_emit_run && (r_row == '0) && (r_col == c_col_first);
        r_eol   <= w_emit_flush;
      end
      if (w_emit_flush) begin
        r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
      end
      if (r_state == S_DONE) begin
        r_done <= 1'b1;
        r_col  <= '0;
        r_row  <= '0;
      end
    end
  end

  assign win_o   = r_win;
  assign valid_o = r_valid;
  assign sof_o   = r_sof;
  assign eol_o   = r_eol;
  assign done_o  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
// tb_sobel_window_gen : scoreboard bench for three sobel_window_gen instances
//                       (5x6 zero pad, 5x6 replicate, 2x2 zero pad).
// Revision: 1.0
// ============================================================================
module tb_sobel_window_gen;

  typedef struct {
    logic [71:0] win;
    logic        sof;
    logic        eol;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_a = 1'b0;
  logic        valid_c = 1'b0;
  logic [7:0]  top_d = '0;
  logic [7:0]  mid_d = '0;
  logic [7:0]  bot_d = '0;

  logic        ready_a, ready_b, ready_c;
  logic [71:0] win_a, win_b, win_c;
  logic        vo_a, vo_b, vo_c;
  logic        sof_a, sof_b, sof_c;
  logic        eol_a, eol_b, eol_c;
  logic        done_a, done_b, done_c;

  int n_checks = 0;
  int n_err    = 0;
  int nwin_a = 0, nwin_b = 0, nwin_c = 0;
  int ndone_a = 0, ndone_b = 0, ndone_c = 0;
  logic dexp_a = 1'b0, dexp_b = 1'b0, dexp_c = 1'b0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  always #5 clk = ~clk;

  sobel_window_gen #(.DATA_WIDTH(8), .ROWS(5), .COLS(6), .PAD_MODE(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_a), .ready_o(ready_a),
    .top_i(top_d), .mid_i(mid_d), .bot_i(bot_d), .win_o(win_a),
    .valid_o(vo_a), .sof_o(sof_a), .eol_o(eol_a), .done_o(done_a));

  sobel_window_gen #(.DATA_WIDTH(8), .ROWS(5), .COLS(6), .PAD_MODE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_a), .ready_o(ready_b),
    .top_i(top_d), .mid_i(mid_d), .bot_i(bot_d), .win_o(win_b),
    .valid_o(vo_b), .sof_o(sof_b), .eol_o(eol_b), .done_o(done_b));

  sobel_window_gen #(.DATA_WIDTH(8), .ROWS(2), .COLS(2), .PAD_MODE(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_c), .ready_o(ready_c),
    .top_i(top_d), .mid_i(mid_d), .bot_i(bot_d), .win_o(win_c),
    .valid_o(vo_c), .sof_o(sof_c), .eol_o(eol_c), .done_o(done_c));

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference pixel with edge handling done by clamping coordinates.
  function automatic logic [7:0] ref_px(int r, int c, int rows, int cols, bit pad);
    if (r < 0 || r >= rows || c < 0 || c >= cols) begin
      if (!pad) return 8'd0;
      if (r < 0) r = 0;
      if (r >= rows) r = rows - 1;
      if (c < 0) c = 0;
      if (c >= cols) c = cols - 1;
    end
    return 8'(cols * r + c);
  endfunction

  function automatic exp_t mk_exp(int r, int c, int rows, int cols, bit pad);
    exp_t e;
    e.win = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        e.win[((dr + 1) * 3 + (dc + 1)) * 8 +: 8] = ref_px(r + dr, c + dc, rows, cols, pad);
    e.sof  = (r == 0) && (c == 0);
    e.eol  = (c == cols - 1);
    e.last = (c == cols - 1) && (r == rows - 1);
    return e;
  endfunction

  task automatic push_exp(input int dsel, input int r, input int c, input int rows, input int cols);
    if (dsel == 0) begin
      qa.push_back(mk_exp(r, c, rows, cols, 1'b0));
      qb.push_back(mk_exp(r, c, rows, cols, 1'b1));
    end else begin
      qc.push_back(mk_exp(r, c, rows, cols, 1'b0));
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge following accept.
  task automatic drive_col(input int dsel, input int r, input int c, input int rows,
                           input int cols, input bit stall);
    int   waits;
    logic rdy;
    if (stall) begin
      while ($urandom_range(1, 0) == 1) begin
        valid_a = 1'b0;
        valid_c = 1'b0;
        @(negedge clk);
      end
    end
    top_d = (r == 0) ? 8'hFF : 8'(cols * (r - 1) + c);
    mid_d = 8'(cols * r + c);
    bot_d = (r == rows - 1) ? 8'hFF : 8'(cols * (r + 1) + c);
    if (dsel == 0) valid_a = 1'b1;
    else valid_c = 1'b1;
    waits = 0;
    rdy = (dsel == 0) ? ready_a : ready_c;
    while (!rdy && waits < 20) begin
      @(negedge clk);
      waits++;
      rdy = (dsel == 0) ? ready_a : ready_c;
    end
    if (!rdy) check_eq("accept_timeout", 72'(rdy), 72'd1);
    @(posedge clk);
    if (c >= 1) push_exp(dsel, r, c - 1, rows, cols);
    if (c == cols - 1) push_exp(dsel, r, cols - 1, rows, cols);
    @(negedge clk);
    valid_a = 1'b0;
    valid_c = 1'b0;
    if (dsel == 0 && !stall && c == 0 && r > 0) check_eq("flush_wait", 72'(waits), 72'd1);
    if (dsel == 0 && c == cols - 1) begin
      check_eq("A_flush_rdy", 72'(ready_a), 72'd0);
      check_eq("B_flush_rdy", 72'(ready_b), 72'd0);
    end
  endtask

  task automatic run_frame(input int dsel, input int rows, input int cols,
                           input bit stall, input int max_beats);
    int beats;
    beats = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        if (beats < max_beats) begin
          drive_col(dsel, r, c, rows, cols, stall);
          beats++;
        end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_win"},   win_a, 72'd0);
    check_eq({tag, "_valid"}, 72'(vo_a), 72'd0);
    check_eq({tag, "_sof"},   72'(sof_a), 72'd0);
    check_eq({tag, "_eol"},   72'(eol_a), 72'd0);
    check_eq({tag, "_done"},  72'(done_a), 72'd0);
    check_eq({tag, "_ready"}, 72'(ready_a), 72'd0);
    check_eq({tag, "_winB"},  win_b, 72'd0);
    check_eq({tag, "_winC"},  win_c, 72'd0);
  endtask

  // Output monitor and scoreboard consumer for all three instances.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      dexp_a = 1'b0;
      dexp_b = 1'b0;
      dexp_c = 1'b0;
    end else begin
      if (done_a || dexp_a) check_eq("A_done", 72'(done_a), 72'(dexp_a));
      if (done_a) ndone_a++;
      dexp_a = 1'b0;
      if (vo_a) begin
        if (qa.size() == 0) check_eq("A_spurious_valid", 72'(vo_a), 72'd0);
        else begin
          e = qa.pop_front();
          check_eq("A_win", win_a, e.win);
          check_eq("A_sof", 72'(sof_a), 72'(e.sof));
          check_eq("A_eol", 72'(eol_a), 72'(e.eol));
          nwin_a++;
          dexp_a = e.last;
        end
      end

      if (done_b || dexp_b) check_eq("B_done", 72'(done_b), 72'(dexp_b));
      if (done_b) ndone_b++;
      dexp_b = 1'b0;
      if (vo_b) begin
        if (qb.size() == 0) check_eq("B_spurious_valid", 72'(vo_b), 72'd0);
        else begin
          e = qb.pop_front();
          check_eq("B_win", win_b, e.win);
          check_eq("B_sof", 72'(sof_b), 72'(e.sof));
          check_eq("B_eol", 72'(eol_b), 72'(e.eol));
          nwin_b++;
          dexp_b = e.last;
        end
      end

      if (done_c || dexp_c) check_eq("C_done", 72'(done_c), 72'(dexp_c));
      if (done_c) ndone_c++;
      dexp_c = 1'b0;
      if (vo_c) begin
        if (qc.size() == 0) check_eq("C_spurious_valid", 72'(vo_c), 72'd0);
        else begin
          e = qc.pop_front();
          check_eq("C_win", win_c, e.win);
          check_eq("C_sof", 72'(sof_c), 72'(e.sof));
          check_eq("C_eol", 72'(eol_c), 72'(e.eol));
          nwin_c++;
          dexp_c = e.last;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bw_a, bw_b, bw_c, bd_a, bd_b, bd_c;

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    check_eq("rst_release_ready", 72'(ready_a), 72'd1);
    @(negedge clk);

    // T1/T2/T3: full frame, valid held high
    bw_a = nwin_a; bw_b = nwin_b; bd_a = ndone_a; bd_b = ndone_b;
    run_frame(0, 5, 6, 1'b0, 30);
    repeat (4) @(negedge clk);
    check_eq("T1_win_count", 72'(nwin_a - bw_a), 72'd30);
    check_eq("T2_win_count", 72'(nwin_b - bw_b), 72'd30);
    check_eq("T1_done_count", 72'(ndone_a - bd_a), 72'd1);
    check_eq("T2_done_count", 72'(ndone_b - bd_b), 72'd1);

    // T4: random input stalls
    bw_a = nwin_a; bd_a = ndone_a;
    run_frame(0, 5, 6, 1'b1, 30);
    repeat (4) @(negedge clk);
    check_eq("T4_win_count", 72'(nwin_a - bw_a), 72'd30);
    check_eq("T4_done_count", 72'(ndone_a - bd_a), 72'd1);

    // T5: reset after the 14th accept, then a fresh frame
    run_frame(0, 5, 6, 1'b0, 14);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("T5_rst");
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bw_a = nwin_a; bw_b = nwin_b; bd_a = ndone_a;
    run_frame(0, 5, 6, 1'b0, 30);
    repeat (4) @(negedge clk);
    check_eq("T5_win_count", 72'(nwin_a - bw_a), 72'd30);
    check_eq("T5_win_countB", 72'(nwin_b - bw_b), 72'd30);
    check_eq("T5_done_count", 72'(ndone_a - bd_a), 72'd1);

    // T6: 2x2 frame
    bw_c = nwin_c; bd_c = ndone_c;
    run_frame(2, 2, 2, 1'b0, 4);
    repeat (4) @(negedge clk);
    check_eq("T6_win_count", 72'(nwin_c - bw_c), 72'd4);
    check_eq("T6_done_count", 72'(ndone_c - bd_c), 72'd1);
    check_eq("queue_empty", 72'(qa.size() + qb.size() + qc.size()), 72'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
